// File: rtl/sargantana_way_array.sv
// Multi-way icache data array: N_WAYS banks, one shared index, all ways read per access.
// Optional even parity per word when SARGANTANA_ICACHE_PARITY_EN is defined.
module sargantana_way_array #(
  parameter  int LINE_WIDTH = 256,
  parameter  int WORD_WIDTH = 32,
  parameter  int ADDR_WIDTH = 6,
  parameter  int N_WAYS     = 4,
  localparam int N_WORDS    = LINE_WIDTH / WORD_WIDTH,
  localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [N_WAYS-1:0]            way_we_i,
  input  logic [N_WORDS-1:0]           word_en_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [LINE_WIDTH-1:0]        data_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [N_WAYS*LINE_WIDTH-1:0] data_o,
  output logic [N_WAYS-1:0]            parity_err_o
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    valid_q;
  logic                    clearing;
  logic                    acc;
  logic                    rd_acc;
  logic                    wr_acc;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [N_WAYS-1:0][N_WORDS-1:0] word_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= rd_acc;
    end
  end

  // INIT and FLUSH share the same clear walk; flush_i is only heard in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT, ST_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (flush_i) state_d = ST_FLUSH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign clearing = ~ready_o;
  assign acc      = ready_o & req_i & ~flush_i;
  assign rd_acc   = acc & ~we_i;
  assign wr_acc   = acc & we_i;
  assign wr_addr  = clearing ? cnt_q : addr_i;
  assign valid_o  = valid_q;

  genvar gi, gk;
  generate
    for (gi = 0; gi < N_WAYS; gi++) begin : g_way
      for (gk = 0; gk < N_WORDS; gk++) begin : g_word
        logic [WORD_WIDTH-1:0] mem_q [DEPTH];
        logic [WORD_WIDTH-1:0] rd_q;
        logic                  wr_en;
        logic [WORD_WIDTH-1:0] wr_word;

        assign wr_en   = clearing | (wr_acc & way_we_i[gi] & word_en_i[gk]);
        assign wr_word = clearing ? '0 : data_i[gk*WORD_WIDTH +: WORD_WIDTH];

        always_ff @(posedge clk_i) begin
          if (wr_en) mem_q[wr_addr] <= wr_word;
        end

        // Output register resets and holds between reads; the array itself does not reset.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i)       rd_q <= '0;
          else if (rd_acc) rd_q <= mem_q[addr_i];
        end

        assign data_o[(gi*N_WORDS+gk)*WORD_WIDTH +: WORD_WIDTH] = rd_q;

`ifdef SARGANTANA_ICACHE_PARITY_EN
        logic par_q [DEPTH];
        logic perr_q;

        always_ff @(posedge clk_i) begin
          if (wr_en) par_q[wr_addr] <= ^wr_word;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i)       perr_q <= 1'b0;
          else if (rd_acc) perr_q <= (^mem_q[addr_i]) ^ par_q[addr_i];
        end

        assign word_err[gi][gk] = perr_q;
`else
        assign word_err[gi][gk] = 1'b0;
`endif
      end
      assign parity_err_o[gi] = |word_err[gi];
    end
  endgenerate

endmodule
